// File: rtl/ocd_frame_sender_if.sv
// ocd_frame_sender_if: command handshake between a host and the OCD frame sender
interface ocd_frame_sender_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_type;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  modport master (output cmd_valid, cmd_type, cmd_addr, cmd_data, input cmd_ready);
  modport slave (input cmd_valid, cmd_type, cmd_addr, cmd_data, output cmd_ready);
endinterface

// File: rtl/ocd_frame_sender.sv
// ocd_frame_sender: serialises a 12-byte OCD command frame as 8N1 UART with a trailing idle gap
module ocd_frame_sender #(
  parameter int BAUD_PERIOD = 16,
  parameter int GAP_BITS = 2
) (
  input  logic clk,
  input  logic reset_n,
  ocd_frame_sender_if.slave cmd,
  output logic TXD,
  output logic busy,
  output logic frame_done
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;
  state_t state, state_d;
  logic [15:0] baud_cnt, baud_d;
  logic [2:0] bit_idx, bit_d;
  logic [3:0] byte_idx, byte_d;
  logic [3:0] gap_cnt, gap_d;
  logic [7:0] frame [12];
  logic [7:0] sum, cur_byte;
  logic bit_end, accept, done_d, txd_d;
  assign bit_end = baud_cnt == 16'(BAUD_PERIOD - 1);
  assign accept = state == IDLE && cmd.cmd_valid;
  assign sum = cmd.cmd_type + cmd.cmd_addr[31:24] + cmd.cmd_addr[23:16] + cmd.cmd_addr[15:8]
             + cmd.cmd_addr[7:0] + cmd.cmd_data[31:24] + cmd.cmd_data[23:16]
             + cmd.cmd_data[15:8] + cmd.cmd_data[7:0];
  assign cur_byte = frame[byte_d];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      gap_cnt <= '0;
      TXD <= 1'b1;
      frame_done <= 1'b0;
      for (int i = 0; i < 12; i++) frame[i] <= '0;
    end else begin
      state <= state_d;
      baud_cnt <= baud_d;
      bit_idx <= bit_d;
      byte_idx <= byte_d;
      gap_cnt <= gap_d;
      TXD <= txd_d;
      frame_done <= done_d;
      if (accept)
        frame <= '{8'h5A, 8'hA5, cmd.cmd_type, cmd.cmd_addr[31:24], cmd.cmd_addr[23:16],
                   cmd.cmd_addr[15:8], cmd.cmd_addr[7:0], cmd.cmd_data[31:24],
                   cmd.cmd_data[23:16], cmd.cmd_data[15:8], cmd.cmd_data[7:0], 8'h00 - sum};
    end
  always_comb begin
    state_d = state;
    baud_d = bit_end ? '0 : baud_cnt + 16'd1;
    bit_d = bit_idx;
    byte_d = byte_idx;
    gap_d = gap_cnt;
    done_d = 1'b0;
    case (state)
      IDLE: begin
        baud_d = '0;
        if (cmd.cmd_valid) begin
          state_d = START;
          bit_d = '0;
          byte_d = '0;
          gap_d = '0;
        end
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d = '0;
      end
      DATA: if (bit_end) begin
        bit_d = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_d = STOP;
      end
      STOP: if (bit_end) begin
        if (byte_idx != 4'd11) begin
          state_d = START;
          byte_d = byte_idx + 4'd1;
        end else begin
          state_d = GAP_BITS == 0 ? IDLE : GAP;
          done_d = GAP_BITS == 0;
          byte_d = '0;
          gap_d = '0;
        end
      end
      GAP: if (bit_end) begin
        gap_d = gap_cnt + 4'd1;
        if (gap_cnt == 4'(GAP_BITS - 1)) begin
          state_d = IDLE;
          done_d = 1'b1;
          gap_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // TXD is registered, so it is computed from the state being entered
  always_comb begin
    txd_d = state_d == START ? 1'b0 : state_d == DATA ? cur_byte[bit_d] : 1'b1;
    busy = state != IDLE;
    cmd.cmd_ready = state == IDLE;
  end
endmodule

// File: doc/ocd_frame_sender.md
OCD_FRAME_SENDER -- requirements
Module: ocd_frame_sender

Interface
REQ-001 SHALL have parameter BAUD_PERIOD, default 16, meaning clocks per UART bit time (legal range 2..65535).
REQ-002 SHALL have parameter GAP_BITS, default 2, meaning idle bit times inserted after each frame's final stop bit (legal range 0..15).
REQ-003 SHALL have port clk  input  1  single clock; every flop is clocked on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert and active-low.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  sender can accept a command.
REQ-007 SHALL have port cmd_type  input  8  OCD command byte.
REQ-008 SHALL have port cmd_addr  input  32  command address.
REQ-009 SHALL have port cmd_data  input  32  command data word.
REQ-010 SHALL have port TXD  output  1  serial line to the OCD RXD (8N1, idle high).
REQ-011 SHALL have port busy  output  1  high while a frame or its trailing gap is in progress.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at the end of each frame's gap.

Function
REQ-013 SHALL accept a command on a clk edge where cmd_valid and cmd_ready are both high, registering cmd_type, cmd_addr and cmd_data at that edge.
REQ-014 SHALL hold cmd_ready high only in IDLE and low from the acceptance edge until frame_done.
REQ-015 SHALL transmit a 12-byte frame with bytes in this order: 0x5A, 0xA5, cmd_type, cmd_addr[31:24], [23:16], [15:8], [7:0], cmd_data[31:24], [23:16], [15:8], [7:0], checksum.
REQ-016 SHALL compute checksum as the 8-bit two's complement of the mod-256 sum of frame bytes 2..10, so that bytes 2..11 sum to 0x00 mod 256.
REQ-017 SHALL serialise each byte as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), each bit held on TXD for exactly BAUD_PERIOD clocks.
REQ-018 SHALL drive TXD low for the start bit of byte 0 beginning on the first clock after the acceptance edge; TXD SHALL be registered.
REQ-019 SHALL place bytes back to back with no idle between one stop bit and the next start bit.
REQ-020 SHALL hold TXD high for GAP_BITS*BAUD_PERIOD clocks after the stop bit of byte 11.
REQ-021 SHALL pulse frame_done for one cycle after the last gap clock, and assert cmd_ready in that same cycle.
REQ-022 SHALL make the total time from acceptance edge to frame_done equal to (120+GAP_BITS)*BAUD_PERIOD clocks.
REQ-023 SHALL implement the state machine IDLE->START->DATA->STOP with these transitions: STOP->START while byte index < 11; STOP->GAP when byte index = 11; GAP->IDLE when the gap count expires; STOP->IDLE directly when GAP_BITS = 0.
REQ-024 SHALL use a 16-bit baud counter, a 3-bit bit index, a 4-bit byte index and a 4-bit gap counter, all cleared on every state entry.
REQ-025 SHALL ignore cmd_valid and all command inputs while busy, so that changes to the inputs mid-frame do not alter the transmitted bytes.
REQ-026 SHALL drive busy high in every state except IDLE.
REQ-027 SHALL accept a command held on cmd_valid in the frame_done cycle at that edge, with no idle cycle inserted beyond the gap.

Reset
REQ-028 SHALL force, while reset_n is low and independent of clk, state=IDLE, TXD=1, cmd_ready=1, busy=0, frame_done=0, and all counters and the frame register to 0.
REQ-029 SHALL, on reset assertion mid-frame, abort the frame immediately and not emit frame_done.
REQ-030 SHALL resume normal operation on the first clk edge after reset_n deasserts.

Verification
REQ-031 SHALL cover: BAUD_PERIOD=4, GAP_BITS=2, cmd type 0x01, addr 0x80000000, data 0xDEADBEEF -> decoded bytes 5A A5 01 80 00 00 00 DE AD BE EF 47, frame_done 488 clocks after acceptance.
REQ-032 SHALL cover: an all-zero command -> bytes 5A A5 00 00 00 00 00 00 00 00 00 00, every stop bit = 1.
REQ-033 SHALL cover: cmd_valid held high across two commands -> second acceptance in the frame_done cycle, TXD low on the next clock, cmd_ready low for 487 of the 488 clocks.
REQ-034 SHALL cover: reset_n pulsed low during byte 5 -> TXD=1 in the same cycle, no frame_done, cmd_ready=1 after release.
REQ-035 SHALL cover: cmd_data changed while busy -> transmitted bytes unchanged.
REQ-036 SHALL cover: GAP_BITS=0, BAUD_PERIOD=2 -> frame_done 240 clocks after acceptance.
